icache_nextline_prefetcher: RTL and testbench
=============================================

// Module: icache_nextline_prefetcher
// PURPOSE
//  Sits between the icache miss port and the cacheline adapter. Forwards demand line fills on the
//  adapter's icache channel, then issues a next-line prefetch (line+32B) on the nextline channel.
//  Holds one prefetched line in a buffer; icache misses that hit it are served without memory.
// PARAMETERS
//  PF_ENABLE    1   0: never assert nl_read; block is a pure demand pass-through
//  OFFSET_BITS  5   log2(line bytes); line = 256b, tag = addr[31:OFFSET_BITS]
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous active-high reset
//  ic_addr      in   32   icache miss address (low OFFSET_BITS ignored)
//  ic_read      in   1    icache miss request; held stable until ic_resp
//  ic_rdata     out  256  fill line, valid only with ic_resp
//  ic_resp      out  1    one-cycle fill-done pulse
//  flush        in   1    fence.i: invalidate buffer, discard in-flight prefetch
//  mem_addr     out  32   to adapter icache_addr, line aligned
//  mem_read     out  1    to adapter icache_read; level, held until mem_resp
//  mem_rdata    in   256  from adapter icache_rdata
//  mem_resp     in   1    from adapter icache_resp
//  nl_addr      out  32   to adapter next_line_addr; stable while nl_read high
//  nl_read      out  1    to adapter next_line_read; level, held until nl_resp
//  nl_rdata     in   256  from adapter next_line_data
//  nl_resp      in   1    from adapter nl_mem_resp
//  pf_issued    out  32   prefetches completed (wraps at 2^32)
//  pf_hits      out  32   demand requests served from buffer/in-flight prefetch (wraps)
// BEHAVIOUR
//  Reset: state IDLE; buf_valid=0; counters=0; ic_resp, mem_read, nl_read, drop_q = 0; data x.
//  Invariant: mem_read and nl_read never high in the same cycle.
//  States:
//   IDLE   ic_read & buf_valid & tag match -> RESP.  ic_read & miss -> DEMAND.
//   RESP   ic_resp=1, ic_rdata=buf_data (1 cycle after sample); pf_hits++;
//          buf_valid stays 1 -> PREFETCH (line+1) if eligible, else IDLE.
//   DEMAND mem_read=1, mem_addr={ic_addr[31:5],5'b0}. On mem_resp: ic_resp=1,
//          ic_rdata=mem_rdata (combinational pass-through) -> PREFETCH if eligible, else IDLE.
//   PREFETCH  nl_read=1, nl_addr=pf_addr_q. Wait for nl_resp. On nl_resp:
//          if !drop_q: buf_data<=nl_rdata, buf_tag<=pf_addr_q tag, buf_valid<=1, pf_issued++.
//          If ic_read & ic_addr line==pf_addr_q & !drop_q: also ic_resp=1,
//          ic_rdata=nl_rdata that cycle, pf_hits++ (in-flight hit).
//          -> IDLE; an unserved ic_read is then resolved by IDLE next cycle.
//  Eligible prefetch: PF_ENABLE=1, target=line+32 does not wrap past 0xFFFFFFE0
//   (no prefetch after line 0xFFFFFFE0), and target != buf_tag while buf_valid.
//   pf_addr_q is latched on entry to PREFETCH.
//  ic_read in PREFETCH is never forwarded to mem_read; the prefetch is not cancellable.
//  flush: buf_valid<=0 next cycle; in PREFETCH, set drop_q (cleared on leaving PREFETCH);
//   in RESP the response still completes. flush and hit in the same IDLE cycle: flush wins, miss.
//  Mid-transaction reset: immediate return to reset values. The adapter shares rst.
// TESTING
//  Cold miss 0x1000_0004: mem_read with mem_addr=0x1000_0000; mem_resp+data D0 -> ic_resp same
//   cycle with D0; next cycle nl_read with nl_addr=0x1000_0020.
//  After nl_resp data D1, ic_read 0x1000_0020 -> ic_resp 1 cycle after sample with D1,
//   mem_read never high, nl_addr=0x1000_0040, pf_hits=1.
//  ic_read 0x1000_0020 while prefetch is in flight -> ic_resp in the nl_resp cycle with
//   nl_rdata; ic_read 0x2000_0000 in flight -> nl_resp, then mem_read 0x2000_0000.
//  Demand at 0xFFFF_FFE0 -> fill completes, nl_read stays 0.
//  flush during PREFETCH -> buffer stays invalid, no bypass, pf_issued unchanged;
//   re-request of the same line goes to mem_read.
//  rst asserted mid-DEMAND -> next cycle all outputs at reset values; PF_ENABLE=0 -> nl_read never 1.

Source files
------------

// File: rtl/icache_nextline_prefetcher_if.sv
// Bundle between the icache miss port, the prefetcher and the cacheline adapter.
// master = request/memory side environment, slave = prefetcher.
interface icache_nextline_prefetcher_if;
  logic [31:0]  ic_addr;
  logic         ic_read;
  logic [255:0] ic_rdata;
  logic         ic_resp;
  logic         flush;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [31:0]  nl_addr;
  logic         nl_read;
  logic [255:0] nl_rdata;
  logic         nl_resp;
  logic [31:0]  pf_issued;
  logic [31:0]  pf_hits;

  modport master (
    output ic_addr, ic_read, flush, mem_rdata, mem_resp, nl_rdata, nl_resp,
    input  ic_rdata, ic_resp, mem_addr, mem_read, nl_addr, nl_read, pf_issued, pf_hits
  );

  modport slave (
    input  ic_addr, ic_read, flush, mem_rdata, mem_resp, nl_rdata, nl_resp,
    output ic_rdata, ic_resp, mem_addr, mem_read, nl_addr, nl_read, pf_issued, pf_hits
  );
endinterface

// File: rtl/icache_nextline_prefetcher.sv
// Next-line instruction prefetcher: forwards demand fills, then prefetches line+1 into a
// single-line buffer that later icache misses (or an in-flight match) are served from.
module icache_nextline_prefetcher #(
  parameter bit          PF_ENABLE   = 1'b1,
  parameter int unsigned OFFSET_BITS = 5
) (
  input logic                        clk,
  input logic                        rst,
  icache_nextline_prefetcher_if.slave bus
);
  localparam int unsigned TW = 32 - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, RESP, DEMAND, PREFETCH} state_e;

  state_e         state_q, state_d;
  logic           buf_valid_q, buf_valid_d;
  logic [TW-1:0]  buf_tag_q, buf_tag_d;
  logic [255:0]   buf_data_q, buf_data_d;
  logic [TW-1:0]  pf_addr_q, pf_addr_d;
  logic           drop_q, drop_d;
  logic [31:0]    pf_issued_q, pf_issued_d;
  logic [31:0]    pf_hits_q, pf_hits_d;

  logic [TW-1:0]  ic_line, next_line;
  logic           buf_hit, pf_eligible, pf_drop, inflight_hit;
  logic           ic_resp, mem_read, nl_read;
  logic [255:0]   ic_rdata;
  logic           unused_offset;

  assign ic_line       = bus.ic_addr[31:OFFSET_BITS];
  assign next_line     = ic_line + TW'(1);
  assign unused_offset = ^bus.ic_addr[OFFSET_BITS-1:0];

  // A flush in the same cycle as a buffer hit forces a miss.
  assign buf_hit      = bus.ic_read & buf_valid_q & (buf_tag_q == ic_line) & ~bus.flush;
  assign pf_eligible  = PF_ENABLE & (ic_line != '1) & ~(buf_valid_q & (buf_tag_q == next_line));
  assign pf_drop      = drop_q | bus.flush;
  assign inflight_hit = bus.ic_read & (ic_line == pf_addr_q) & ~pf_drop;

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q & ~bus.flush;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    pf_addr_d   = pf_addr_q;
    drop_d      = drop_q;
    pf_issued_d = pf_issued_q;
    pf_hits_d   = pf_hits_q;
    ic_resp     = 1'b0;
    ic_rdata    = buf_data_q;
    mem_read    = 1'b0;
    nl_read     = 1'b0;

    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (bus.ic_read) begin
          state_d = buf_hit ? RESP : DEMAND;
        end
      end
      RESP: begin
        ic_resp   = 1'b1;
        pf_hits_d = pf_hits_q + 32'd1;
        if (pf_eligible) begin
          state_d   = PREFETCH;
          pf_addr_d = next_line;
        end else begin
          state_d = IDLE;
        end
      end
      DEMAND: begin
        mem_read = 1'b1;
        ic_rdata = bus.mem_rdata;
        if (bus.mem_resp) begin
          ic_resp = 1'b1;
          if (pf_eligible) begin
            state_d   = PREFETCH;
            pf_addr_d = next_line;
          end else begin
            state_d = IDLE;
          end
        end
      end
      PREFETCH: begin
        nl_read  = 1'b1;
        ic_rdata = bus.nl_rdata;
        if (bus.flush) begin
          drop_d = 1'b1;
        end
        if (bus.nl_resp) begin
          if (!pf_drop) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = pf_addr_q;
            buf_data_d  = bus.nl_rdata;
            pf_issued_d = pf_issued_q + 32'd1;
          end
          if (inflight_hit) begin
            ic_resp   = 1'b1;
            pf_hits_d = pf_hits_q + 32'd1;
          end
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      pf_addr_q   <= '0;
      drop_q      <= 1'b0;
      pf_issued_q <= '0;
      pf_hits_q   <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      pf_addr_q   <= pf_addr_d;
      drop_q      <= drop_d;
      pf_issued_q <= pf_issued_d;
      pf_hits_q   <= pf_hits_d;
    end
  end

  // Line data is qualified by buf_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
  end

  assign bus.ic_resp   = ic_resp;
  assign bus.ic_rdata  = ic_rdata;
  assign bus.mem_read  = mem_read;
  assign bus.mem_addr  = {ic_line, {OFFSET_BITS{1'b0}}};
  assign bus.nl_read   = nl_read;
  assign bus.nl_addr   = {pf_addr_q, {OFFSET_BITS{1'b0}}};
  assign bus.pf_issued = pf_issued_q;
  assign bus.pf_hits   = pf_hits_q;
endmodule

// File: tb/tb_icache_nextline_prefetcher.sv
// Bench for icache_nextline_prefetcher: acts as icache and adapter, predicting hits, prefetch
// targets and counters from a transaction-level model of the prefetch buffer.
module tb_icache_nextline_prefetcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_nextline_prefetcher_if bus ();
  icache_nextline_prefetcher_if bus0 ();

  icache_nextline_prefetcher #(.PF_ENABLE(1'b1), .OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  icache_nextline_prefetcher #(.PF_ENABLE(1'b0), .OFFSET_BITS(5)) dut_nopf (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // model: one buffered line, a pending prefetch expectation, counters
  logic        m_valid = 1'b0;
  logic [26:0] m_tag = '0;
  logic        m_pf = 1'b0;
  logic [26:0] m_tgt = '0;
  int unsigned m_issued = 0;
  int unsigned m_hits = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [255:0] lineval(input logic [26:0] l);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = {l, i[4:0]} * 32'h9E3779B1 + 32'h0BADC0DE;
    return v;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_pf_hits"}, bus.pf_hits, m_hits);
    chk({tag, "_pf_issued"}, bus.pf_issued, m_issued);
  endtask

  // Runs the expected prefetch to completion; optional in-flight request and flush.
  task automatic do_prefetch(input logic inflight, input logic [26:0] l, input logic [4:0] off,
                             input logic fl, output logic served);
    int unsigned lat;
    logic drop;
    served = 1'b0;
    drop = 1'b0;
    lat = fl ? $urandom_range(1, 3) : $urandom_range(0, 3);
    if (inflight) begin
      bus.ic_addr = {l, off};
      bus.ic_read = 1'b1;
    end
    for (int unsigned c = 0; c <= lat; c++) begin
      if (fl && c == 0) begin
        bus.flush = 1'b1;
        drop = 1'b1;
      end
      if (c == lat) begin
        bus.nl_resp  = 1'b1;
        bus.nl_rdata = lineval(m_tgt);
      end
      @(negedge clk);
      chk("pf_nl_read", bus.nl_read, 1'b1);
      chk("pf_nl_addr", bus.nl_addr, {m_tgt, 5'b0});
      chk("pf_mem_read", bus.mem_read, 1'b0);
      if (c == lat) begin
        if (inflight && l == m_tgt && !drop) begin
          chk("inflight_resp", bus.ic_resp, 1'b1);
          chk("inflight_data", bus.ic_rdata, lineval(l));
          served = 1'b1;
        end else begin
          chk("pf_no_resp", bus.ic_resp, 1'b0);
        end
      end
      @(posedge clk); #1;
      bus.flush   = 1'b0;
      bus.nl_resp = 1'b0;
      bus.nl_rdata = '0;
    end
    if (!drop) begin
      m_valid = 1'b1;
      m_tag = m_tgt;
      m_issued++;
    end else begin
      m_valid = 1'b0;
    end
    if (served) begin
      m_hits++;
      bus.ic_read = 1'b0;
    end
    m_pf = 1'b0;
  endtask

  task automatic demand(input logic [26:0] l, input logic [4:0] off, input logic fl,
                        input logic already);
    logic hit;
    int unsigned lat;
    if (!already) begin
      bus.ic_addr = {l, off};
      bus.ic_read = 1'b1;
      if (fl) begin
        bus.flush = 1'b1;
        m_valid = 1'b0;
      end
    end
    hit = m_valid && (m_tag == l);
    @(negedge clk);
    chk("idle_resp", bus.ic_resp, 1'b0);
    chk("idle_mem_read", bus.mem_read, 1'b0);
    chk("idle_nl_read", bus.nl_read, 1'b0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (hit) begin
      @(negedge clk);
      chk("hit_resp", bus.ic_resp, 1'b1);
      chk("hit_data", bus.ic_rdata, lineval(l));
      chk("hit_mem_read", bus.mem_read, 1'b0);
      m_hits++;
    end else begin
      lat = $urandom_range(0, 3);
      for (int unsigned c = 0; c <= lat; c++) begin
        if (c == lat) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = lineval(l);
        end
        @(negedge clk);
        chk("dem_mem_read", bus.mem_read, 1'b1);
        chk("dem_mem_addr", bus.mem_addr, {l, 5'b0});
        chk("dem_nl_read", bus.nl_read, 1'b0);
        chk("dem_resp", bus.ic_resp, c == lat);
        if (c == lat) chk("dem_data", bus.ic_rdata, lineval(l));
        if (c != lat) begin
          @(posedge clk); #1;
        end
      end
    end
    @(posedge clk); #1;
    bus.ic_read   = 1'b0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    m_pf  = (l != 27'h7FFFFFF) && !(m_valid && m_tag == l + 27'd1);
    m_tgt = l + 27'd1;
  endtask

  task automatic request(input logic [26:0] l, input logic [4:0] off, input logic inflight,
                         input logic fl);
    logic served, had_pf;
    served = 1'b0;
    had_pf = m_pf;
    if (m_pf) do_prefetch(inflight, l, off, fl, served);
    if (!served) demand(l, off, fl && !(had_pf && inflight), had_pf && inflight);
    chk_counters("req");
  endtask

  initial begin
    logic [26:0] l;
    bus.ic_addr = '0;  bus.ic_read = 1'b0; bus.flush = 1'b0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0; bus.nl_rdata = '0; bus.nl_resp = 1'b0;
    bus0.ic_addr = '0; bus0.ic_read = 1'b0; bus0.flush = 1'b0;
    bus0.mem_rdata = '0; bus0.mem_resp = 1'b0; bus0.nl_rdata = '0; bus0.nl_resp = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ic_resp", bus.ic_resp, 1'b0);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_nl_read", bus.nl_read, 1'b0);
    chk_counters("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // cold miss at 0x1000_0004, then hit on the prefetched 0x1000_0020
    request(27'h0800000, 5'd4, 1'b0, 1'b0);
    chk("cold_pf_target", {m_pf, m_tgt, 5'b0}, {1'b1, 32'h1000_0020});
    request(27'h0800001, 5'd0, 1'b0, 1'b0);
    chk("dir_pf_hits", bus.pf_hits, 32'd1);
    // in-flight hit on 0x1000_0040, then in-flight miss forwarded after nl_resp
    request(27'h0800002, 5'd8, 1'b1, 1'b0);
    request(27'h0900000, 5'd0, 1'b0, 1'b0);
    request(27'h1000000, 5'd0, 1'b1, 1'b0);
    // top line: fill completes, no prefetch follows
    request(27'h7FFFFFF, 5'd0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("top_no_nl_read", bus.nl_read, 1'b0);
      @(posedge clk); #1;
    end

    // reset in the middle of a demand fill
    bus.ic_addr = 32'h3000_0000;
    bus.ic_read = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_mem_read", bus.mem_read, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ic_read = 1'b0;
    m_valid = 1'b0; m_pf = 1'b0; m_hits = 0; m_issued = 0;
    @(negedge clk);
    chk("mid_rst_ic_resp", bus.ic_resp, 1'b0);
    chk("mid_rst_mem_read", bus.mem_read, 1'b0);
    chk("mid_rst_nl_read", bus.nl_read, 1'b0);
    chk_counters("mid_rst");
    @(posedge clk); #1;

    // flush while prefetching: dropped line, re-request goes to memory
    request(27'h0A00000, 5'd0, 1'b0, 1'b0);
    request(27'h0A00001, 5'd0, 1'b0, 1'b1);
    chk("flush_pf_issued", bus.pf_issued, 32'd0);

    for (int unsigned it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: l = m_tgt;
        4:          l = m_tag;
        5:          l = m_tgt + 27'($urandom_range(1, 2));
        6:          l = 27'h7FFFFFE + 27'($urandom_range(0, 1));
        default:    l = 27'h0100000 + 27'($urandom_range(0, 15));
      endcase
      request(l, 5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end

    // PF_ENABLE=0 instance: pure pass-through
    bus0.ic_addr = 32'h1000_0000;
    bus0.ic_read = 1'b1;
    @(negedge clk);
    chk("nopf_idle_nl", bus0.nl_read, 1'b0);
    @(posedge clk); #1;
    bus0.mem_resp = 1'b1;
    bus0.mem_rdata = lineval(27'h0800000);
    @(negedge clk);
    chk("nopf_mem_read", bus0.mem_read, 1'b1);
    chk("nopf_resp", bus0.ic_resp, 1'b1);
    chk("nopf_data", bus0.ic_rdata, lineval(27'h0800000));
    @(posedge clk); #1;
    bus0.ic_read = 1'b0;
    bus0.mem_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("nopf_nl_read", bus0.nl_read, 1'b0);
      @(posedge clk); #1;
    end
    chk("nopf_issued", bus0.pf_issued, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
